izh_neuron_array: RTL and testbench
===================================

Name: izh_neuron_array

Overview:
- Time-multiplexed array of NUM_NEURONS Izhikevich neurons sharing one fixed-point update datapath and one multiplier.
- Each neuron holds its own v/u state, input current and behaviour mode.
- A start pulse sweeps all neurons once (one Euler step each) and reports a spike vector.
- Successor to the single-neuron tile; sits behind the host config/IO logic.

Parameters:
- NUM_NEURONS, 4, neurons in array (>=2, power of 2 not required).
- DATA_W, 18, signed state width.
- FRAC_W, 16, fractional bits (format Q(DATA_W-FRAC_W).FRAC_W).
- IDX_W, $clog2(NUM_NEURONS), index width (derived, not overridden).

Ports:
- clk, in, 1, clock.
- rst_n, in, 1, synchronous active-low reset.
- en, in, 1, FSM advance enable; low freezes all state.
- start, in, 1, one-cycle request for a sweep.
- wr_en, in, 1, config write strobe.
- wr_sel, in, 1, 0 = current register, 1 = mode register.
- wr_idx, in, IDX_W, target neuron.
- wr_data, in, 8, current (signed) or mode (bits [1:0]).
- rd_idx, in, IDX_W, neuron to read back.
- v_rd, out, DATA_W, v of rd_idx, registered.
- busy, out, 1, sweep in progress.
- done, out, 1, one-cycle pulse at sweep end.
- spike, out, NUM_NEURONS, fire flags of the last completed sweep.

Behaviour:
- Reset, applied on clk edge when rst_n=0 regardless of en:
  - every v = -0.7 (18-bit 0x34CCD); every u = -0.2 (0x3CCCD).
  - all currents 0; all modes 0.
  - FSM to IDLE; busy=0, done=0, spike=0, v_rd=0.
  - Reset mid-sweep abandons the sweep; no done is issued.
- FSM has three states: IDLE, UPDATE, DONE. All transitions require en=1; with en=0, state, idx and neuron state hold.
  - IDLE: when start=1, go to UPDATE with idx=0. start is ignored outside IDLE.
  - UPDATE: busy=1. Each cycle neuron idx is updated at the clock edge and idx increments. After idx=NUM_NEURONS-1 is written, go to DONE.
  - DONE: done=1 for one cycle; spike loads the accumulated pending flags, which are then cleared. Return to IDLE.
- Latency: start sampled at edge E gives busy during cycles E+1..E+N and done during cycle E+N+1. Back-to-back start is accepted in the IDLE cycle after DONE.
- Per-neuron update, arithmetic shifts, DATA_W wrap unless IZH_SAT_EN:
  - vsq = mult(v,v) = (v*v full 2*DATA_W product) >>> FRAC_W, truncated to DATA_W.
  - I = {wr_data current, DATA_W-8 zeros}.
  - sum = vsq + v + (v>>>2) + (C14>>>2) - (u>>>2) + (I>>>2), with C14 = 1.4.
  - v_new = v + (sum>>>2).
  - u_new = u + ((((v>>>B_SH) - u) >>> A_SH) >>> 4).
  - Fire if v > VPEAK (0.30, 0x04CCC). On fire: v <= C, u <= u + D, and the pending flag is set. Otherwise v <= v_new, u <= u_new.
- Mode table (A_SH, B_SH, C, D):
  - 0 RS: 6, 2, -0.7, 0.2
  - 1 IB: 6, 2, -0.55, 0.1
  - 2 CH: 6, 2, -0.5, 0.05
  - 3 FS: 3, 1, -0.7, 0.05
- Config writes:
  - Take effect at the edge they are sampled, independent of en and FSM state.
  - A write to the neuron being updated in the same cycle does not affect that update; it applies from the next sweep.
- v_rd updates every cycle to v[rd_idx] as of the previous edge, giving one-cycle latency.

Optional Feature:
- Macro IZH_SAT_EN.
- Defined: v_new, u_new and u+D saturate to the signed DATA_W range (max 0x1FFFF / min 0x20000 for 18-bit).
- Undefined: two's-complement wrap.

Decomposition:
- Package izh_pkg holds:
  - mode_t (2-bit enum RS/IB/CH/FS) and the mode parameter struct (a_sh, b_sh, c, d).
  - Preset table function.
  - Constants VPEAK, C14, V_RST, U_RST, expressed via FRAC_W.
- One sub-module, izh_mult: parametrised signed DATA_W multiply returning the product >>> FRAC_W.

Test Plan:
- Reset, then read v_rd for each idx -> 0x34CCD for all; spike=0, busy=0.
- Mode 0, current 0, one sweep -> neuron0 v matches golden model (exact bits); done exactly N+1 cycles after the start edge; spike=0.
- Current 0x7F on neuron 1 only, repeated sweeps -> neuron 1 fires first; spike=4'b0010 in that sweep; its v then reads C = -0.7 and u increments by 0.2.
- start during busy, and en=0 mid-sweep for 5 cycles -> extra start ignored; done delayed by exactly 5 cycles; results are bit-identical to an uninterrupted sweep.
- rst_n=0 at idx=2 mid-sweep -> all state back to reset values; no done pulse.
- IZH_SAT_EN with state forced near +max and I=0x7F -> v clamps to 0x1FFFF (no sign flip); without the macro it wraps.

Source files
------------

// File: rtl/izh_pkg.sv
// Shared types and constants for the Izhikevich neuron array.
// Fixed-point constants are derived from milli-unit values and the
// fractional width, so they follow any FRAC_W override.
package izh_pkg;

    typedef enum logic [1:0] {
        MODE_RS = 2'd0,
        MODE_IB = 2'd1,
        MODE_CH = 2'd2,
        MODE_FS = 2'd3
    } mode_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_UPDATE = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    typedef struct packed {
        logic [3:0] a_sh;
        logic [3:0] b_sh;
        int         c;
        int         d;
    } mode_prm_t;

    localparam int VPEAK_M = 300;
    localparam int C14_M   = 1400;
    localparam int V_RST_M = -700;
    localparam int U_RST_M = -200;

    // milli-units to fixed point, truncating toward zero
    function automatic int fx(input int milli, input int frac_w);
        return int'((longint'(milli) <<< frac_w) / 64'sd1000);
    endfunction

    function automatic mode_prm_t izh_preset(input mode_t m, input int frac_w);
        mode_prm_t p;
        p = '{a_sh: 4'd6, b_sh: 4'd2, c: fx(-700, frac_w), d: fx(200, frac_w)};
        case (m)
            MODE_IB: p = '{a_sh: 4'd6, b_sh: 4'd2, c: fx(-550, frac_w), d: fx(100, frac_w)};
            MODE_CH: p = '{a_sh: 4'd6, b_sh: 4'd2, c: fx(-500, frac_w), d: fx(50, frac_w)};
            MODE_FS: p = '{a_sh: 4'd3, b_sh: 4'd1, c: fx(-700, frac_w), d: fx(50, frac_w)};
            default: ;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/izh_mult.sv
// Signed fixed-point multiply: full product shifted right by FRAC_W,
// truncated back to DATA_W.
module izh_mult #(
    parameter int DATA_W = 18,
    parameter int FRAC_W = 16
) (
    input  logic signed [DATA_W-1:0] a,
    input  logic signed [DATA_W-1:0] b,
    output logic signed [DATA_W-1:0] p
);

    logic signed [2*DATA_W-1:0] full;

    // full-width product, then rescale
    always_comb begin
        full = a * b;
        p    = DATA_W'(full >>> FRAC_W);
    end

endmodule

// File: rtl/izh_neuron_array.sv
// Time-multiplexed array of Izhikevich neurons sharing one update datapath.
// Optional macro IZH_SAT_EN: saturate v_new, u_new and u+D instead of wrapping.
module izh_neuron_array
    import izh_pkg::*;
#(
    parameter  int NUM_NEURONS = 4,
    parameter  int DATA_W      = 18,
    parameter  int FRAC_W      = 16,
    localparam int IDX_W       = $clog2(NUM_NEURONS)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic                     start,
    input  logic                     wr_en,
    input  logic                     wr_sel,
    input  logic [IDX_W-1:0]         wr_idx,
    input  logic [7:0]               wr_data,
    input  logic [IDX_W-1:0]         rd_idx,
    output logic signed [DATA_W-1:0] v_rd,
    output logic                     busy,
    output logic                     done,
    output logic [NUM_NEURONS-1:0]   spike
);

    localparam logic signed [DATA_W-1:0] VPEAK_Q = DATA_W'(fx(VPEAK_M, FRAC_W));
    localparam logic signed [DATA_W-1:0] C14_Q   = DATA_W'(fx(C14_M, FRAC_W) >>> 2);
    localparam logic signed [DATA_W-1:0] V_RST_Q = DATA_W'(fx(V_RST_M, FRAC_W));
    localparam logic signed [DATA_W-1:0] U_RST_Q = DATA_W'(fx(U_RST_M, FRAC_W));

    logic signed [DATA_W-1:0] v_mem   [NUM_NEURONS];
    logic signed [DATA_W-1:0] u_mem   [NUM_NEURONS];
    logic signed [7:0]        cur_mem [NUM_NEURONS];
    mode_t                    mode_mem[NUM_NEURONS];

    state_t                   state;
    logic [IDX_W-1:0]         idx;
    logic [NUM_NEURONS-1:0]   pending;

    mode_prm_t                prm;
    logic signed [DATA_W-1:0] v_cur, u_cur, i_cur, vsq, sum, du_diff, du;
    logic signed [DATA_W-1:0] v_next, u_next;
    logic                     fire;
    logic [NUM_NEURONS-1:0]   fire_vec;

    function automatic logic signed [DATA_W-1:0] add_fit(
        input logic signed [DATA_W-1:0] a,
        input logic signed [DATA_W-1:0] b
    );
`ifdef IZH_SAT_EN
        logic [DATA_W:0] s;
        s = {a[DATA_W-1], a} + {b[DATA_W-1], b};
        if (s[DATA_W] != s[DATA_W-1])
            return s[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
        return s[DATA_W-1:0];
`else
        return a + b;
`endif
    endfunction

    izh_mult #(.DATA_W(DATA_W), .FRAC_W(FRAC_W)) u_mult (
        .a (v_cur),
        .b (v_cur),
        .p (vsq)
    );

    // Euler step of the neuron currently selected by idx
    always_comb begin
        prm      = izh_preset(mode_mem[idx], FRAC_W);
        v_cur    = v_mem[idx];
        u_cur    = u_mem[idx];
        i_cur    = {cur_mem[idx], {(DATA_W-8){1'b0}}};
        sum      = vsq + v_cur + (v_cur >>> 2) + C14_Q - (u_cur >>> 2) + (i_cur >>> 2);
        du_diff  = (v_cur >>> prm.b_sh) - u_cur;
        du       = (du_diff >>> prm.a_sh) >>> 4;
        fire     = v_cur > VPEAK_Q;
        v_next   = fire ? DATA_W'(prm.c) : add_fit(v_cur, sum >>> 2);
        u_next   = fire ? add_fit(u_cur, DATA_W'(prm.d)) : add_fit(u_cur, du);
        fire_vec = '0;
        fire_vec[idx] = fire;
    end

    // sweep FSM and neuron state; spike is loaded together with done
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            idx     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            spike   <= '0;
            pending <= '0;
            for (int unsigned i = 0; i < NUM_NEURONS; i++) begin
                v_mem[i] <= V_RST_Q;
                u_mem[i] <= U_RST_Q;
            end
        end else if (en) begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state <= ST_UPDATE;
                        idx   <= '0;
                        busy  <= 1'b1;
                    end
                end
                ST_UPDATE: begin
                    v_mem[idx] <= v_next;
                    u_mem[idx] <= u_next;
                    if (idx == IDX_W'(NUM_NEURONS - 1)) begin
                        state   <= ST_DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        spike   <= pending | fire_vec;
                        pending <= '0;
                    end else begin
                        pending <= pending | fire_vec;
                        idx     <= idx + 1'b1;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // host configuration writes, independent of en and FSM state
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_NEURONS; i++) begin
                cur_mem[i]  <= '0;
                mode_mem[i] <= MODE_RS;
            end
        end else if (wr_en && (int'(wr_idx) < NUM_NEURONS)) begin
            if (wr_sel)
                mode_mem[wr_idx] <= mode_t'(wr_data[1:0]);
            else
                cur_mem[wr_idx] <= wr_data;
        end
    end

    // registered readback of the selected neuron's v
    always_ff @(posedge clk) begin
        if (!rst_n)
            v_rd <= '0;
        else if (int'(rd_idx) < NUM_NEURONS)
            v_rd <= v_mem[rd_idx];
    end

endmodule

// File: tb/tb_izh_neuron_array.sv
// Randomized bench for izh_neuron_array against an integer reference model.
// Build with or without IZH_SAT_EN; the model follows the same macro.
module tb_izh_neuron_array;

    localparam int N  = 4;
    localparam int DW = 18;
    localparam int FW = 16;
    localparam int IW = 2;

    localparam int V_REST = -45875;
    localparam int U_REST = -13107;
    localparam int VPEAK  = 19660;
    localparam int C14Q   = 22937;   // 1.4 = 91750, >>> 2

    logic clk = 1'b0;
    logic rst_n, en, start, wr_en, wr_sel;
    logic [IW-1:0] wr_idx, rd_idx;
    logic [7:0] wr_data;
    logic signed [DW-1:0] v_rd;
    logic busy, done;
    logic [N-1:0] spike;

    always #5 clk = ~clk;

    izh_neuron_array #(.NUM_NEURONS(N), .DATA_W(DW), .FRAC_W(FW)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .start(start),
        .wr_en(wr_en), .wr_sel(wr_sel), .wr_idx(wr_idx), .wr_data(wr_data),
        .rd_idx(rd_idx), .v_rd(v_rd), .busy(busy), .done(done), .spike(spike)
    );

    int total = 0;
    int bad   = 0;

    int mv[N], mu[N], mcur[N], mmode[N];
    logic [N-1:0] mspk;

    task automatic check(input string tag, input longint got, input longint exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    function automatic int wrap(input longint x);
        longint m;
        m = x & 64'h3FFFF;
        if (m >= 64'h20000) m -= 64'h40000;
        return int'(m);
    endfunction

    function automatic int fit(input longint x);
`ifdef IZH_SAT_EN
        if (x > 131071) return 131071;
        if (x < -131072) return -131072;
        return int'(x);
`else
        return wrap(x);
`endif
    endfunction

    function automatic int a_of(input int m); return (m == 3) ? 3 : 6; endfunction
    function automatic int b_of(input int m); return (m == 3) ? 1 : 2; endfunction
    function automatic int c_of(input int m);
        case (m)
            1: return -36044;
            2: return -32768;
            default: return -45875;
        endcase
    endfunction
    function automatic int d_of(input int m);
        case (m)
            0: return 13107;
            1: return 6553;
            default: return 3276;
        endcase
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < N; i++) begin
            mv[i] = V_REST; mu[i] = U_REST; mcur[i] = 0; mmode[i] = 0;
        end
        mspk = '0;
    endfunction

    // one Euler step for every neuron, in index order
    function automatic void model_sweep();
        int v, u, vsq, iv, sum, diff, du;
        mspk = '0;
        for (int i = 0; i < N; i++) begin
            v = mv[i]; u = mu[i];
            if (v > VPEAK) begin
                mv[i] = c_of(mmode[i]);
                mu[i] = fit(longint'(u) + d_of(mmode[i]));
                mspk[i] = 1'b1;
            end else begin
                vsq  = wrap((longint'(v) * v) >>> 16);
                iv   = mcur[i] * 1024;
                sum  = wrap(longint'(vsq) + v + (v >>> 2) + C14Q - (u >>> 2) + (iv >>> 2));
                mv[i] = fit(longint'(v) + (sum >>> 2));
                diff = wrap(longint'(v >>> b_of(mmode[i])) - u);
                du   = (diff >>> a_of(mmode[i])) >>> 4;
                mu[i] = fit(longint'(u) + du);
            end
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic write_cfg(input bit sel, input int idx, input logic [7:0] data);
        wr_en = 1'b1; wr_sel = sel; wr_idx = IW'(idx); wr_data = data;
        tick();
        wr_en = 1'b0;
        if (sel) mmode[idx] = int'(data[1:0]);
        else     mcur[idx]  = int'($signed(data));
    endtask

    task automatic read_all(input string tag);
        for (int i = 0; i < N; i++) begin
            rd_idx = IW'(i);
            tick();
            check($sformatf("%s_v%0d", tag, i), longint'(v_rd), longint'(mv[i]));
        end
    endtask

    // start a sweep; optional stall window and a stray start while busy
    task automatic do_sweep(input string tag, input int stall_at, input int stall_len,
                            input bit extra_start);
        int k;
        bit got;
        model_sweep();
        start = 1'b1;
        tick();
        start = 1'b0;
        k = 1; got = 1'b0;
        while (!got && k <= N + 1 + stall_len + 4) begin
            if (k == 1) check({tag, "_busy"}, longint'(busy), 1);
            if (done) begin
                got = 1'b1;
            end else begin
                start = (extra_start && k == 2);
                en = !(stall_len > 0 && k >= stall_at && k < stall_at + stall_len);
                tick();
                k++;
            end
        end
        en = 1'b1; start = 1'b0;
        check({tag, "_lat"}, got ? k : -1, N + 1 + stall_len);
        check({tag, "_spk"}, longint'(spike), longint'(mspk));
        tick();
        check({tag, "_done1"}, longint'(done), 0);
        if (extra_start) begin
            tick();
            check({tag, "_nostart"}, longint'(busy), 0);
        end
    endtask

    initial begin
        logic [N-1:0] first_spk;
        int cnt_done;

        rst_n = 1'b0; en = 1'b1; start = 1'b0; wr_en = 1'b0; wr_sel = 1'b0;
        wr_idx = '0; wr_data = '0; rd_idx = '0;
        model_reset();
        repeat (3) tick();
        check("rst_vrd", longint'(v_rd), 0);
        check("rst_busy", longint'(busy), 0);
        check("rst_done", longint'(done), 0);
        check("rst_spk", longint'(spike), 0);
        rst_n = 1'b1;
        read_all("rst");

        // plain sweep from reset, mode 0, current 0
        do_sweep("sw0", 0, 0, 1'b0);
        read_all("sw0");

        // neuron 1 driven hard until it fires
        write_cfg(1'b0, 1, 8'h7F);
        first_spk = '0;
        for (int s = 0; s < 60 && first_spk == '0; s++) begin
            do_sweep("drv", 0, 0, 1'b0);
            if (mspk != '0 || spike != '0) begin
                first_spk = spike;
                read_all("fire");
                check("fire_c", longint'(mv[1]), -45875);
            end
        end
        check("first_spike", longint'(first_spk), 4'b0010);

        // stray start while busy plus 5-cycle en stall
        do_sweep("stall", 2, 5, 1'b1);
        read_all("stall");

        // randomized configurations
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < N; i++) begin
                write_cfg(1'b1, i, 8'($urandom_range(0, 3)));
                write_cfg(1'b0, i, 8'($urandom_range(0, 255)));
            end
            for (int s = 0; s < 3; s++) begin
                do_sweep("rnd", int'($urandom_range(1, 4)), int'($urandom_range(0, 3)),
                         1'($urandom_range(0, 1)));
            end
            read_all("rnd");
        end

        // reset while idx=2 is being updated
        start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        model_reset();
        cnt_done = 0;
        for (int c = 0; c < 2 * N + 2; c++) begin
            if (done) cnt_done++;
            tick();
        end
        check("mrst_nodone", cnt_done, 0);
        check("mrst_busy", longint'(busy), 0);
        check("mrst_spk", longint'(spike), 0);
        read_all("mrst");
        do_sweep("post", 0, 0, 1'b0);
        read_all("post");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
